// File: rtl/gray_stream_checker_pkg.sv
// rtl/gray_stream_checker_pkg.sv - shared FSM state type and Gray decode helper for Gray-domain blocks
package gray_stream_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_RECOVER = 2'd2
  } chk_state_e;

  localparam int GRAY_MAX_W = 32;

  // Callers zero-extend; binary bit i is the XOR of Gray bits width-1 down to i.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g,
                                                     input int width);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      if (i < width) b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// rtl/gray_sync.sv - multi-stage flop synchroniser for a Gray-coded bus
module gray_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/gray_stream_checker.sv
// rtl/gray_stream_checker.sv - synchronises a Gray stream, decodes it and classifies each step
module gray_stream_checker
  import gray_stream_checker_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_N      = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] g_in,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] b_out,
  output logic             b_valid,
  output logic             step_up,
  output logic             step_down,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic             locked
);

  localparam int GOOD_W = $clog2(LOCK_N + 1);

  chk_state_e       state_q, state_d;
  logic [WIDTH-1:0] g_s, b;
  logic [GOOD_W-1:0] good_cnt, good_cnt_d;
  logic             is_hold, is_up, is_down, is_err, relock;
  logic [WIDTH-1:0] b_out_d;
  logic [ERR_W-1:0] err_cnt_d;
  logic             b_valid_d, step_up_d, step_down_d, err_pulse_d, locked_d;

  gray_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (g_in),
    .q     (g_s)
  );

  assign b       = WIDTH'(gray2bin(GRAY_MAX_W'(g_s), WIDTH));
  assign is_hold = (b == b_out);
  assign is_up   = (b == b_out + WIDTH'(1));
  assign is_down = (b == b_out - WIDTH'(1));
  assign is_err  = !(is_hold || is_up || is_down);
  // The current good sample is the LOCK_N-th in a row.
  assign relock  = (good_cnt == GOOD_W'(LOCK_N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else if (en) begin
      case (state_q)
        ST_IDLE:    state_d = ST_TRACK;
        ST_TRACK:   if (is_err) state_d = ST_RECOVER;
        ST_RECOVER: if (!is_err && relock) state_d = ST_TRACK;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    b_out_d     = b_out;
    b_valid_d   = b_valid;
    locked_d    = locked;
    err_cnt_d   = err_cnt;
    good_cnt_d  = good_cnt;
    step_up_d   = 1'b0;
    step_down_d = 1'b0;
    err_pulse_d = 1'b0;
    if (clr) begin
      b_valid_d  = 1'b0;
      locked_d   = 1'b0;
      err_cnt_d  = '0;
      good_cnt_d = '0;
    end else if (en) begin
      b_out_d = b;
      if (state_q == ST_IDLE) begin
        b_valid_d  = 1'b1;
        locked_d   = 1'b1;
        good_cnt_d = '0;
      end else begin
        step_up_d   = is_up;
        step_down_d = is_down;
        err_pulse_d = is_err;
        if (is_err) begin
          locked_d   = 1'b0;
          good_cnt_d = '0;
          if (err_cnt != '1) err_cnt_d = err_cnt + ERR_W'(1);
        end else if (state_q == ST_RECOVER) begin
          if (relock) begin
            locked_d   = 1'b1;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt + GOOD_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_out     <= '0;
      b_valid   <= 1'b0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      good_cnt  <= '0;
      locked    <= 1'b0;
    end else begin
      b_out     <= b_out_d;
      b_valid   <= b_valid_d;
      step_up   <= step_up_d;
      step_down <= step_down_d;
      err_pulse <= err_pulse_d;
      err_cnt   <= err_cnt_d;
      good_cnt  <= good_cnt_d;
      locked    <= locked_d;
    end
  end

endmodule

// File: tb/tb_gray_stream_checker.sv
// tb/tb_gray_stream_checker.sv - randomized and directed bench for gray_stream_checker
module tb_gray_stream_checker;

  localparam int W  = 4;
  localparam int S  = 2;
  localparam int LN = 4;
  localparam int EW = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] g_in = '0;
  logic         en = 1'b0;
  logic         clr = 1'b0;

  logic [W-1:0]  b_out, sat_b_out;
  logic          b_valid, step_up, step_down, err_pulse, locked;
  logic          sat_b_valid, sat_step_up, sat_step_down, sat_err_pulse, sat_locked;
  logic [EW-1:0] err_cnt;
  logic [1:0]    sat_err_cnt;

  int checks = 0;
  int fails  = 0;

  gray_stream_checker #(.WIDTH(W), .SYNC_STAGES(S), .LOCK_N(LN), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .g_in(g_in), .en(en), .clr(clr),
    .b_out(b_out), .b_valid(b_valid), .step_up(step_up), .step_down(step_down),
    .err_pulse(err_pulse), .err_cnt(err_cnt), .locked(locked)
  );

  gray_stream_checker #(.WIDTH(W), .SYNC_STAGES(S), .LOCK_N(LN), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .g_in(g_in), .en(en), .clr(clr),
    .b_out(sat_b_out), .b_valid(sat_b_valid), .step_up(sat_step_up), .step_down(sat_step_down),
    .err_pulse(sat_err_pulse), .err_cnt(sat_err_cnt), .locked(sat_locked)
  );

  always #5 clk = ~clk;

  // Reference model: delayed samples, last accepted value, lock flag, raw error tally.
  int m_q[$];
  int m_ref, m_good, m_errs;
  bit m_have_ref, m_lock, m_up, m_down, m_err;
  int n_up, n_down, n_err;

  function automatic int enc(int v);
    return v ^ (v >> 1);
  endfunction

  function automatic int dec(int g);
    for (int v = 0; v < 16; v++) if (enc(v) == g) return v;
    return -1;
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [18:0] exp_vec();
    return {4'(m_ref), m_have_ref, m_up, m_down, m_err, 8'(sat(m_errs, 255)), m_lock,
            2'(sat(m_errs, 3))};
  endfunction

  function automatic logic [18:0] obs_vec();
    return {b_out, b_valid, step_up, step_down, err_pulse, err_cnt, locked, sat_err_cnt};
  endfunction

  task automatic model_reset();
    m_q = {};
    repeat (S) m_q.push_back(0);
    m_ref = 0; m_good = 0; m_errs = 0;
    m_have_ref = 0; m_lock = 0; m_up = 0; m_down = 0; m_err = 0;
  endtask

  task automatic model_edge(int g, bit e, bit c);
    int gs, b, d;
    gs = m_q.pop_front();
    m_q.push_back(g);
    m_up = 0; m_down = 0; m_err = 0;
    if (c) begin
      m_have_ref = 0; m_lock = 0; m_errs = 0; m_good = 0;
    end else if (e) begin
      b = dec(gs);
      if (!m_have_ref) begin
        m_have_ref = 1; m_lock = 1;
      end else begin
        d = (b - m_ref + 16) % 16;
        m_up = (d == 1); m_down = (d == 15); m_err = (d > 1 && d < 15);
        if (m_err) begin
          m_errs++; m_lock = 0; m_good = 0;
        end else if (!m_lock) begin
          m_good++;
          if (m_good == LN) begin m_lock = 1; m_good = 0; end
        end
      end
      m_ref = b;
    end
  endtask

  task automatic tick(int g, bit e, bit c);
    g_in = W'(g); en = e; clr = c;
    @(posedge clk);
    model_edge(g, e, c);
    #1;
    n_up += int'(step_up); n_down += int'(step_down); n_err += int'(err_pulse);
  endtask

  task automatic preload(int v);
    tick(enc(v), 0, 1);
    repeat (S) tick(enc(v), 0, 0);
    n_up = 0; n_down = 0; n_err = 0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL reset: got %h expected %h", obs_vec(), exp_vec());
    end
    rst_n = 1;
    n_up = 0; n_down = 0; n_err = 0;
  endtask

  task automatic test_count_up();
    int seq[6] = '{0, 1, 2, 3, 3, 3};
    foreach (seq[i]) begin
      tick(enc(seq[i]), 1, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL count_up[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (n_up !== 3 || n_down !== 0 || n_err !== 0 || locked !== 1'b1 || err_cnt !== 8'd0 || b_out !== 4'd3) begin
      fails++;
      $display("FAIL count_up_totals: up=%0d down=%0d err=%0d locked=%b cnt=%0d b=%0d expected 3 0 0 1 0 3",
               n_up, n_down, n_err, locked, err_cnt, b_out);
    end
  endtask

  task automatic test_wrap();
    int seq[7] = '{14, 15, 0, 0, 15, 15, 15};
    preload(14);
    foreach (seq[i]) begin
      tick(enc(seq[i]), 1, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL wrap[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (n_up !== 2 || n_down !== 1 || n_err !== 0) begin
      fails++; $display("FAIL wrap_totals: up=%0d down=%0d err=%0d expected 2 1 0", n_up, n_down, n_err);
    end
  endtask

  task automatic test_error_recover();
    int seq[8] = '{0, 7, 8, 9, 10, 11, 11, 11};
    preload(0);
    foreach (seq[i]) begin
      tick(enc(seq[i]), 1, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL error_recover[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (n_err !== 1 || n_up !== 4 || err_cnt !== 8'd1 || locked !== 1'b1) begin
      fails++;
      $display("FAIL error_recover_totals: err=%0d up=%0d cnt=%0d locked=%b expected 1 4 1 1",
               n_err, n_up, err_cnt, locked);
    end
  endtask

  task automatic test_saturation();
    int seq[8] = '{0, 8, 0, 8, 0, 8, 8, 8};
    preload(0);
    foreach (seq[i]) begin
      tick(enc(seq[i]), 1, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL saturation[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (n_err !== 5 || sat_err_cnt !== 2'd3 || err_cnt !== 8'd5) begin
      fails++;
      $display("FAIL saturation_totals: pulses=%0d sat_cnt=%0d cnt=%0d expected 5 3 5",
               n_err, sat_err_cnt, err_cnt);
    end
  endtask

  task automatic test_enable_freeze();
    preload(3);
    tick(enc(3), 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick(enc(9), 0, 0);
      checks++;
      if (obs_vec() !== exp_vec() || b_out !== 4'd3) begin
        fails++; $display("FAIL freeze[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (n_up + n_down + n_err !== 0) begin
      fails++; $display("FAIL freeze_pulses: got %0d pulses expected 0", n_up + n_down + n_err);
    end
    tick(enc(9), 1, 0);
    checks++;
    if (obs_vec() !== exp_vec() || err_pulse !== 1'b1 || b_out !== 4'd9) begin
      fails++; $display("FAIL freeze_release: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_clr_recover();
    int  seq[6]  = '{0, 5, 5, 5, 5, 5};
    bit  clrs[6] = '{0, 0, 0, 0, 1, 0};
    preload(0);
    foreach (seq[i]) begin
      tick(enc(seq[i]), 1, clrs[i]);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL clr_recover[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (i == 4) begin
        checks++;
        if (b_valid !== 1'b0 || err_cnt !== 8'd0 || locked !== 1'b0 || b_out !== 4'd5) begin
          fails++;
          $display("FAIL clr_state: valid=%b cnt=%0d locked=%b b=%0d expected 0 0 0 5",
                   b_valid, err_cnt, locked, b_out);
        end
      end
    end
    checks++;
    if (n_err !== 1 || b_valid !== 1'b1 || locked !== 1'b1 || step_up || step_down || err_pulse) begin
      fails++; $display("FAIL clr_reload: err=%0d valid=%b locked=%b expected 1 1 1 no pulse",
                        n_err, b_valid, locked);
    end
  endtask

  task automatic test_random();
    int v = 0;
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 85) v = (v + $urandom_range(0, 2) + 15) % 16;
      else        v = $urandom_range(0, 15);
      tick(enc(v), $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) tick(enc(i), 1, 0);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL async_reset: got %h expected %h", obs_vec(), exp_vec());
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick(enc(i + 6), 1, 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL post_reset[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_error_recover();
    test_saturation();
    test_enable_freeze();
    test_clr_recover();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/gray_stream_checker.md
# gray_stream_checker

Registered consumer for a 4-bit Gray-code stream, such as one produced by the team's binary-to-Gray stage. It synchronises the incoming code, decodes it back to binary, and classifies each sample against the previous one as hold, step up or step down. Any non-adjacent transition is flagged and counted as an error. It sits directly downstream of the Gray encoder and feeds position/direction logic and a status register.

## Interface
- WIDTH, 4: Gray/binary code width.
- SYNC_STAGES, 2: input synchroniser depth (≥1).
- LOCK_N, 4: consecutive good samples required to regain lock after an error (≥1).
- ERR_W, 8: error counter width.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- g_in  in  WIDTH  Gray code, possibly asynchronous to clk.
- en  in  1  sample enable; when low the checker state freezes.
- clr  in  1  synchronous clear of tracking state and error count.
- b_out  out  WIDTH  decoded binary of the last accepted sample.
- b_valid  out  1  high once a reference sample has been accepted.
- step_up  out  1  one-cycle pulse: accepted sample = previous + 1 mod 2^WIDTH.
- step_down  out  1  one-cycle pulse: accepted sample = previous − 1 mod 2^WIDTH.
- err_pulse  out  1  one-cycle pulse: non-adjacent transition detected.
- err_cnt  out  ERR_W  saturating error count.
- locked  out  1  tracking with no unresolved error.

## Operation
- Synchroniser: SYNC_STAGES flops on g_in, reset to 0. It runs every cycle regardless of en/clr.
- Decode (combinational on synchroniser output g_s): b[W−1]=g_s[W−1]; b[i]=b[i+1]^g_s[i].
- FSM states: IDLE, TRACK, RECOVER.
  - IDLE (after reset or clr): first cycle with en=1 loads b_out=b and sets b_valid=1, locked=1, then moves to TRACK. No step or err pulse is generated on this cycle.
  - TRACK, en=1, with b_prev = b_out:
    - b==b_prev: hold, no pulse.
    - b==b_prev+1: step_up.
    - b==b_prev−1: step_down.
    - Anything else: err_pulse, err_cnt+1, locked=0, good_cnt=0, go to RECOVER.
    - b_out updates to b in every case.
  - RECOVER: the same classification and step pulses apply.
    - Adjacent or hold sample: good_cnt+1. When good_cnt reaches LOCK_N, set locked=1 and go to TRACK.
    - Another error: err_pulse, err_cnt+1, good_cnt=0, remain in RECOVER.
- Arithmetic is modulo 2^WIDTH. 15→0 is step_up and 0→15 is step_down (Gray 1000↔0000).
- A single-bit Gray change that is not binary-adjacent is an error, e.g. 0000→0100 (0→7).
- err_cnt saturates at 2^ERR_W−1. err_pulse still fires when saturated.
- en=0: b_out, FSM state, counters and locked all hold. All pulses are 0.
- clr=1 (priority over en): go to IDLE; b_valid=0, locked=0, err_cnt=0, good_cnt=0, pulses 0, b_out holds. The synchroniser is not flushed.

## Timing
- Reset values: b_out=0, b_valid=0, step_up=0, step_down=0, err_pulse=0, err_cnt=0, locked=0, FSM=IDLE, synchroniser=0.
- Latency: a g_in change captured at edge k appears on b_out and the pulses after edge k+SYNC_STAGES. That is SYNC_STAGES+1 edges from input to registered output.
- Pulses are registered and last exactly one cycle per accepted sample. At most one of step_up/step_down/err_pulse is high in any cycle.
- Asserting rst_n low mid-stream clears everything immediately. Release is synchronous to the next clk edge.
- clr and en both high in the same cycle: clr wins and that sample is discarded.

## Structure
- Shared package holds the FSM state enum (IDLE, TRACK, RECOVER) and a gray2bin function parameterised by WIDTH, for reuse by other Gray-domain blocks.
- Sub-module: gray_sync (SYNC_STAGES-deep synchroniser with async active-low reset). The checker top holds decode, classify, FSM and counters.

## Test plan
- Reset then en=1 with g_in stepping 0000,0001,0011,0010 (binary 0..3): b_valid after first sample, three step_up pulses, locked=1, err_cnt=0.
- Wrap: binary 14,15,0 then 0,15 (Gray 1001,1000,0000,1000): step_up on 15 and 0; step_down on 15.
- Non-adjacent jump 0000→0100 (0→7) while locked: one err_pulse, err_cnt=1, locked=0. After 4 adjacent samples locked=1.
- ERR_W=2, inject 5 errors: err_cnt=3 at saturation, five err_pulse pulses.
- en=0 while g_in changes 3→9: outputs frozen with no pulses. On en=1 the jump is classified as an error.
- clr asserted in RECOVER with en=1: next cycle IDLE, err_cnt=0, b_valid=0. The next enabled sample reloads the reference with no pulse.
